midi_msg_decoder: RTL and testbench

//  Downstream of the serial byte deframer in the MIDI receiver. Consumes received

---
 rtl/midi_msg_decoder_if.sv | 23 ++
 rtl/midi_msg_decoder.sv | 158 +++++++++++++++
 tb/tb_midi_msg_decoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_msg_decoder_if.sv
// Byte-in / note-event-out bus for midi_msg_decoder.
// master drives received bytes and observes events; slave is the decoder.
interface midi_msg_decoder_if;
  logic [7:0] RX_BYTE;
  logic       RX_VALID;
  logic       RX_FERR;
  logic       EVT_VALID;
  logic       EVT_ON;
  logic [3:0] EVT_CH;
  logic [6:0] EVT_NOTE;
  logic [6:0] EVT_VEL;
  logic [7:0] LED;

  modport master (
    output RX_BYTE, RX_VALID, RX_FERR,
    input  EVT_VALID, EVT_ON, EVT_CH, EVT_NOTE, EVT_VEL, LED
  );

  modport slave (
    input  RX_BYTE, RX_VALID, RX_FERR,
    output EVT_VALID, EVT_ON, EVT_CH, EVT_NOTE, EVT_VEL, LED
  );
endinterface

// File: rtl/midi_msg_decoder.sv
// MIDI channel message decoder: parses Note On/Off from received bytes,
// emits one-cycle events and holds the last sounding note on LED.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running status reuse).
module midi_msg_decoder #(
  parameter logic [3:0] LISTEN_CH = 4'd0,
  parameter logic       OMNI      = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  midi_msg_decoder_if.slave bus
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic RS_EN = 1'b1;
`else
  localparam logic RS_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_D1   = 2'd1;
  localparam logic [1:0] ST_D2   = 2'd2;
  localparam logic [1:0] ST_SKIP = 2'd3;

  // Running status lives in the state itself: IDLE means no status held,
  // so clearing running status is simply a return to IDLE.
  logic [1:0] state_q, state_d;
  logic       is_on_q, is_on_d;
  logic [3:0] ch_q, ch_d;
  logic [6:0] note_q, note_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] reload_q, reload_d;
  logic       evt_valid_q, evt_valid_d;
  logic       evt_on_q, evt_on_d;
  logic [3:0] evt_ch_q, evt_ch_d;
  logic [6:0] evt_note_q, evt_note_d;
  logic [6:0] evt_vel_q, evt_vel_d;
  logic [7:0] led_q, led_d;

  logic [7:0] b;
  assign b = bus.RX_BYTE;

  // Next-state: byte classification, message assembly and event generation
  always_comb begin
    state_d     = state_q;
    is_on_d     = is_on_q;
    ch_d        = ch_q;
    note_d      = note_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    evt_valid_d = 1'b0;
    evt_on_d    = evt_on_q;
    evt_ch_d    = evt_ch_q;
    evt_note_d  = evt_note_q;
    evt_vel_d   = evt_vel_q;
    led_d       = led_q;

    if (bus.RX_VALID) begin
      if (bus.RX_FERR) begin
        state_d = ST_IDLE;
      end else if (b[7:3] == 5'b11111) begin
        // realtime: transparent
      end else if (b[7]) begin
        case (b[7:4])
          4'h8, 4'h9: begin
            if (OMNI || (b[3:0] == LISTEN_CH)) begin
              is_on_d = b[4];
              ch_d    = b[3:0];
              state_d = ST_D1;
            end else begin
              state_d  = ST_SKIP;
              cnt_d    = 2'd2;
              reload_d = 2'd2;
            end
          end
          4'hA, 4'hB, 4'hE: begin
            state_d  = ST_SKIP;
            cnt_d    = 2'd2;
            reload_d = 2'd2;
          end
          4'hC, 4'hD: begin
            state_d  = ST_SKIP;
            cnt_d    = 2'd1;
            reload_d = 2'd1;
          end
          default: state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_D1: begin
            note_d  = b[6:0];
            state_d = ST_D2;
          end
          ST_D2: begin
            evt_valid_d = 1'b1;
            evt_on_d    = is_on_q && (b[6:0] != 7'd0);
            evt_ch_d    = ch_q;
            evt_note_d  = note_q;
            evt_vel_d   = b[6:0];
            if (is_on_q && (b[6:0] != 7'd0)) begin
              led_d = {1'b1, note_q};
            end else if (led_q[6:0] == note_q) begin
              led_d = '0;
            end
            state_d = RS_EN ? ST_D1 : ST_IDLE;
          end
          ST_SKIP: begin
            if (cnt_q == 2'd1) begin
              state_d = RS_EN ? ST_SKIP : ST_IDLE;
              cnt_d   = RS_EN ? reload_q : 2'd0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      is_on_q     <= 1'b0;
      ch_q        <= '0;
      note_q      <= '0;
      cnt_q       <= '0;
      reload_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_on_q    <= 1'b0;
      evt_ch_q    <= '0;
      evt_note_q  <= '0;
      evt_vel_q   <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_on_q     <= is_on_d;
      ch_q        <= ch_d;
      note_q      <= note_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      evt_valid_q <= evt_valid_d;
      evt_on_q    <= evt_on_d;
      evt_ch_q    <= evt_ch_d;
      evt_note_q  <= evt_note_d;
      evt_vel_q   <= evt_vel_d;
      led_q       <= led_d;
    end
  end

  assign bus.EVT_VALID = evt_valid_q;
  assign bus.EVT_ON    = evt_on_q;
  assign bus.EVT_CH    = evt_ch_q;
  assign bus.EVT_NOTE  = evt_note_q;
  assign bus.EVT_VEL   = evt_vel_q;
  assign bus.LED       = led_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Testbench for midi_msg_decoder: two instances (OMNI, and OMNI=0 on channel 2)
// fed the same byte stream, checked every cycle against a message-level model.
module tb_midi_msg_decoder;

  logic CLK;
  logic RESET;

  midi_msg_decoder_if bus0 ();
  midi_msg_decoder_if bus1 ();

  midi_msg_decoder dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0));
  midi_msg_decoder #(.LISTEN_CH(4'd2), .OMNI(1'b0)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks;
  int failures;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Message-level model: remembered status byte plus data bytes collected so far.
  typedef struct {
    logic [7:0] rs;
    logic [6:0] d0;
    int         ndata;
    logic       v;
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
    logic [7:0] led;
  } model_t;

  function automatic model_t step(input model_t mi, input logic [7:0] b, input logic ferr,
                                  input logic omni, input logic [3:0] lch);
    model_t m;
    int len;
    m = mi;
    m.v = 1'b0;
    if (ferr) begin
      m.rs = 8'h00; m.ndata = 0;
    end else if (b >= 8'hF8) begin
      // realtime ignored
    end else if (b[7]) begin
      m.rs    = (b < 8'hF0) ? b : 8'h00;
      m.ndata = 0;
    end else if (m.rs != 8'h00) begin
      len = (m.rs[7:4] == 4'hC || m.rs[7:4] == 4'hD) ? 1 : 2;
      if (m.ndata == 0) m.d0 = b[6:0];
      m.ndata++;
      if (m.ndata == len) begin
        m.ndata = 0;
        if ((m.rs[7:4] == 4'h8 || m.rs[7:4] == 4'h9) && (omni || m.rs[3:0] == lch)) begin
          m.v    = 1'b1;
          m.on   = (m.rs[7:4] == 4'h9) && (b[6:0] != 7'd0);
          m.ch   = m.rs[3:0];
          m.note = m.d0;
          m.vel  = b[6:0];
          if (m.on) m.led = {1'b1, m.d0};
          else if (m.led[6:0] == m.d0) m.led = 8'h00;
        end
`ifndef MIDI_RUNNING_STATUS_EN
        m.rs = 8'h00;
`endif
      end
    end
    return m;
  endfunction

  model_t m0, m1;
  int dev0, dev1, mev0, mev1;

  always @(posedge CLK) begin
    if (!RESET) begin
      m0 <= '{default: 0};
      m1 <= '{default: 0};
    end else if (bus0.RX_VALID) begin
      m0 <= step(m0, bus0.RX_BYTE, bus0.RX_FERR, 1'b1, 4'd0);
      m1 <= step(m1, bus1.RX_BYTE, bus1.RX_FERR, 1'b0, 4'd2);
    end else begin
      m0.v <= 1'b0;
      m1.v <= 1'b0;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    check("d0_valid", int'(bus0.EVT_VALID), int'(m0.v));
    check("d0_on",    int'(bus0.EVT_ON),    int'(m0.on));
    check("d0_ch",    int'(bus0.EVT_CH),    int'(m0.ch));
    check("d0_note",  int'(bus0.EVT_NOTE),  int'(m0.note));
    check("d0_vel",   int'(bus0.EVT_VEL),   int'(m0.vel));
    check("d0_led",   int'(bus0.LED),       int'(m0.led));
    check("d1_valid", int'(bus1.EVT_VALID), int'(m1.v));
    check("d1_on",    int'(bus1.EVT_ON),    int'(m1.on));
    check("d1_ch",    int'(bus1.EVT_CH),    int'(m1.ch));
    check("d1_note",  int'(bus1.EVT_NOTE),  int'(m1.note));
    check("d1_vel",   int'(bus1.EVT_VEL),   int'(m1.vel));
    check("d1_led",   int'(bus1.LED),       int'(m1.led));
    if (bus0.EVT_VALID) dev0++;
    if (bus1.EVT_VALID) dev1++;
    if (m0.v) mev0++;
    if (m1.v) mev1++;
  end

  task automatic send(input logic [7:0] b, input logic ferr = 1'b0);
    bus0.RX_BYTE = b; bus0.RX_FERR = ferr; bus0.RX_VALID = 1'b1;
    bus1.RX_BYTE = b; bus1.RX_FERR = ferr; bus1.RX_VALID = 1'b1;
    @(posedge CLK); #1;
    bus0.RX_VALID = 1'b0;
    bus1.RX_VALID = 1'b0;
    bus0.RX_FERR  = 1'b0;
    bus1.RX_FERR  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    idle(2);
    RESET = 1'b1;
    idle(1);
  endtask

  // Event-count delta check against a literal, on both DUT and model
  task automatic cnt_chk(input string name, input int d_dut, input int d_mod, input int exp);
    check({name, "_dut"}, d_dut, exp);
    check({name, "_model"}, d_mod, exp);
  endtask

  int b0, b1, bm0, bm1;
  task automatic mark();
    b0 = dev0; b1 = dev1; bm0 = mev0; bm1 = mev1;
  endtask

  initial begin
    checks = 0; failures = 0;
    dev0 = 0; dev1 = 0; mev0 = 0; mev1 = 0;
    RESET = 1'b0;
    bus0.RX_BYTE = '0; bus0.RX_VALID = 1'b0; bus0.RX_FERR = 1'b0;
    bus1.RX_BYTE = '0; bus1.RX_VALID = 1'b0; bus1.RX_FERR = 1'b0;
    idle(3);
    check("rst_valid", int'(bus0.EVT_VALID), 0);
    check("rst_led",   int'(bus0.LED), 0);
    check("rst_note",  int'(bus1.EVT_NOTE), 0);
    RESET = 1'b1;
    idle(1);

    // Basic Note On
    mark(); send(8'h90); send(8'h3C); send(8'h64); idle(2);
    cnt_chk("on_cnt", dev0 - b0, mev0 - bm0, 1);
    check("on_on",   int'(bus0.EVT_ON), 1);
    check("on_ch",   int'(bus0.EVT_CH), 0);
    check("on_note", int'(bus0.EVT_NOTE), 'h3C);
    check("on_vel",  int'(bus0.EVT_VEL), 'h64);
    check("on_led",  int'(bus0.LED), 'hBC);
    check("on_led_model", int'(m0.led), 'hBC);

    // Matching Note Off releases LED
    mark(); send(8'h80); send(8'h3C); send(8'h00); idle(2);
    cnt_chk("off_cnt", dev0 - b0, mev0 - bm0, 1);
    check("off_on",  int'(bus0.EVT_ON), 0);
    check("off_led", int'(bus0.LED), 'h00);

    // Releasing a different note keeps LED
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h80); send(8'h3E); send(8'h00); idle(2);
    check("offx_note", int'(bus0.EVT_NOTE), 'h3E);
    check("offx_led",  int'(bus0.LED), 'hBC);

    // Running status on channel 3
    do_reset();
    mark(); send(8'h93); send(8'h40); send(8'h7F); send(8'h41); send(8'h7F); idle(2);
    check("rs_ch", int'(bus0.EVT_CH), 3);
`ifdef MIDI_RUNNING_STATUS_EN
    cnt_chk("rs_cnt", dev0 - b0, mev0 - bm0, 2);
    check("rs_note", int'(bus0.EVT_NOTE), 'h41);
`else
    cnt_chk("rs_cnt", dev0 - b0, mev0 - bm0, 1);
    check("rs_note", int'(bus0.EVT_NOTE), 'h40);
`endif

    // Realtime byte in the middle of a message
    mark(); send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(2);
    cnt_chk("rt_cnt", dev0 - b0, mev0 - bm0, 1);
    check("rt_note", int'(bus0.EVT_NOTE), 'h3C);
    check("rt_vel",  int'(bus0.EVT_VEL), 'h64);

    // Note On with velocity 0 is a Note Off
    mark(); send(8'h90); send(8'h3C); send(8'h00); idle(2);
    check("v0_on",  int'(bus0.EVT_ON), 0);
    check("v0_vel", int'(bus0.EVT_VEL), 0);
    check("v0_led", int'(bus0.LED), 0);

    // Framing error aborts the message
    do_reset();
    mark(); send(8'h90); send(8'h3C); send(8'h64, 1'b1); send(8'h64); idle(2);
    cnt_chk("ferr_cnt", dev0 - b0, mev0 - bm0, 0);

    // Program change skipped, then a fresh note
    mark(); send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h40); idle(2);
    cnt_chk("pc_cnt", dev0 - b0, mev0 - bm0, 1);
    check("pc_note", int'(bus0.EVT_NOTE), 'h30);

    // System common clears running status
    mark(); send(8'h90); send(8'h3C); send(8'h64); send(8'hF0); send(8'h3D); send(8'h65); idle(2);
    cnt_chk("f0_cnt", dev0 - b0, mev0 - bm0, 1);
    check("f0_note", int'(bus0.EVT_NOTE), 'h3C);

    // Channel filter on the OMNI=0 instance
    do_reset();
    mark(); send(8'h91); send(8'h3C); send(8'h64); idle(2);
    cnt_chk("filt_rej", dev1 - b1, mev1 - bm1, 0);
    cnt_chk("filt_omni", dev0 - b0, mev0 - bm0, 1);
    mark(); send(8'h92); send(8'h3C); send(8'h64); idle(2);
    cnt_chk("filt_acc", dev1 - b1, mev1 - bm1, 1);
    check("filt_ch", int'(bus1.EVT_CH), 2);
    check("filt_led", int'(bus1.LED), 'hBC);

    // Reset mid-message, with reset taking priority over a valid byte
    mark(); send(8'h92);
    RESET = 1'b0; send(8'h3C); RESET = 1'b1;
    send(8'h64); idle(2);
    cnt_chk("rstm_cnt", dev1 - b1, mev1 - bm1, 0);
    check("rstm_led1",  int'(bus1.LED), 0);
    check("rstm_note1", int'(bus1.EVT_NOTE), 0);
    check("rstm_led0",  int'(bus0.LED), 0);
    check("rstm_ch1",   int'(bus1.EVT_CH), 0);

    // Back-to-back stream of two full messages with a rejected one between
    mark();
    send(8'h92); send(8'h10); send(8'h20); send(8'h91); send(8'h11); send(8'h21);
    send(8'h82); send(8'h10); send(8'h00); idle(2);
    cnt_chk("b2b_cnt1", dev1 - b1, mev1 - bm1, 2);
    check("b2b_led1", int'(bus1.LED), 0);
    check("b2b_led0", int'(bus0.LED), 'h91);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
